// File: rtl/bet_unit_arbiter_pkg.sv
// Shared constants and helpers for the bet compute-unit arbiter.
package bet_unit_arbiter_pkg;

    localparam int BET_DATA_W      = 32;
    localparam int BET_DATAC_W     = 6;
    localparam int BET_MAX_LATENCY = 31;
    localparam int BET_MAX_REQ     = 4;

    // Increment an index modulo n (n >= 1).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bet_unit_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic             grant_valid,
    output logic [PTR_W-1:0] grant_idx
);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!grant_valid && eligible[i] && (i == ((int'(ptr) + k) % N))) begin
                    grant_valid = 1'b1;
                    grant_idx   = PTR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/bet_unit_arbiter.sv
// Shares one fixed-latency pipelined bet unit among NUM_REQ requesters with
// round-robin issue, a tag pipeline for result routing and backpressure freeze.
module bet_unit_arbiter
    import bet_unit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int LATENCY = 4,
    parameter int TAG_W   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*BET_DATA_W-1:0]  req_dataa,
    input  logic [NUM_REQ*BET_DATA_W-1:0]  req_datab,
    input  logic [NUM_REQ*BET_DATAC_W-1:0] req_datac,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [TAG_W-1:0]               resp_tag,
    output logic [BET_DATA_W-1:0]          resp_result,
    output logic                           unit_aclr,
    output logic                           unit_clk_en,
    output logic [BET_DATA_W-1:0]          unit_dataa,
    output logic [BET_DATA_W-1:0]          unit_datab,
    output logic [BET_DATAC_W-1:0]         unit_datac,
    input  logic [BET_DATA_W-1:0]          unit_result
);

    // Handshakes: a transfer happens on a clk edge where valid & ready are both
    // high; ready never depends on anything but registered state, valid and stall.
    logic [NUM_REQ-1:0] busy;
    logic [NUM_REQ-1:0] eligible;
    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W-1:0]   op_sel;
    logic               grant_valid;
    logic               stall;
    logic               issue;
    logic               retire;
    logic [LATENCY-1:0] pipe_v;
    logic [TAG_W-1:0]   pipe_tag [LATENCY];

    assign resp_valid  = pipe_v[LATENCY-1];
    assign resp_tag    = pipe_tag[LATENCY-1];
    assign resp_result = unit_result;
    assign unit_aclr   = reset;

    assign stall       = resp_valid & ~resp_ready;
    assign unit_clk_en = ~stall;
    assign eligible    = req_valid & ~busy;
    assign issue       = grant_valid & ~stall & ~reset;
    assign retire      = resp_valid & resp_ready;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (TAG_W)
    ) u_rr_arbiter (
        .eligible    (eligible),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Idle cycles still present rr_ptr's operands; the unit ignores them since v=0.
    assign op_sel = grant_valid ? grant_idx : rr_ptr;

    always_comb begin
        req_ready  = '0;
        unit_dataa = '0;
        unit_datab = '0;
        unit_datac = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (issue && (grant_idx == TAG_W'(i))) begin
                req_ready[i] = 1'b1;
            end
            if (op_sel == TAG_W'(i)) begin
                unit_dataa = req_dataa[i*BET_DATA_W +: BET_DATA_W];
                unit_datab = req_datab[i*BET_DATA_W +: BET_DATA_W];
                unit_datac = req_datac[i*BET_DATAC_W +: BET_DATAC_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= '0;
            rr_ptr <= '0;
            pipe_v <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pipe_tag[k] <= '0;
            end
        end else begin
            // Retire and issue never hit the same requester: busy blocks re-issue.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (retire && (resp_tag == TAG_W'(i))) begin
                    busy[i] <= 1'b0;
                end
                if (issue && (grant_idx == TAG_W'(i))) begin
                    busy[i] <= 1'b1;
                end
            end
            if (issue) begin
                rr_ptr <= TAG_W'(wrap_inc(int'(grant_idx), NUM_REQ));
            end
            if (unit_clk_en) begin
                pipe_v[0]   <= issue;
                pipe_tag[0] <= grant_idx;
                for (int k = 1; k < LATENCY; k++) begin
                    pipe_v[k]   <= pipe_v[k-1];
                    pipe_tag[k] <= pipe_tag[k-1];
                end
            end
        end
    end

endmodule
